// File: rtl/golf_pkg.sv
// Shared course-map definitions: terrain cell encoding, map geometry and frame magic.
// Imported by the map loader and by the gameplay and render blocks.
package golf_pkg;

    typedef enum logic [1:0] {
        HOLE  = 2'd0,
        WALL  = 2'd1,
        GRASS = 2'd2,
        SAND  = 2'd3
    } terrain_t;

    localparam int unsigned MAP_W      = 160;
    localparam int unsigned MAP_H      = 90;
    localparam int unsigned MAP_ADDR_W = 16;
    localparam logic [7:0]  MAP_MAGIC  = 8'hA5;

endpackage

// File: rtl/terrain_map_loader.sv
// Writer side of the terrain map RAM: receives a framed course stream (magic, start cell,
// packed 2-bit cells, XOR checksum) and writes the unpacked cells row-major into the map.
module terrain_map_loader #(
    parameter int unsigned MAP_W  = golf_pkg::MAP_W,
    parameter int unsigned MAP_H  = golf_pkg::MAP_H,
    parameter int unsigned ADDR_W = golf_pkg::MAP_ADDR_W,
    parameter logic [7:0]  MAGIC  = golf_pkg::MAP_MAGIC
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        wr_data,
    output logic [7:0]        start_x,
    output logic [7:0]        start_y,
    output logic              busy,
    output logic              map_valid,
    output logic              load_error
);
    import golf_pkg::*;

    localparam int unsigned CELLS = MAP_W * MAP_H;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_HDR_X, S_HDR_Y, S_PAYLOAD, S_UNPACK, S_CHECK, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         chk_q, chk_d;
    logic [5:0]         sh_q, sh_d;
    logic [2:0]         nib_q, nib_d;
    logic               byte_ready_d, wr_en_d, busy_d, map_valid_d, load_error_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    terrain_t           wr_cell_d;
    logic [7:0]         start_x_d, start_y_d;
    logic               xfer_c, cells_done_c, start_ok_c;

    assign xfer_c       = byte_valid & byte_ready;
    assign cells_done_c = (cnt_q == CNT_W'(CELLS));
    assign start_ok_c   = (32'(start_x) < MAP_W) && (32'(start_y) < MAP_H);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            chk_q      <= '0;
            sh_q       <= '0;
            nib_q      <= '0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            start_x    <= '0;
            start_y    <= '0;
            busy       <= 1'b0;
            map_valid  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            sh_q       <= sh_d;
            nib_q      <= nib_d;
            byte_ready <= byte_ready_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_cell_d;
            start_x    <= start_x_d;
            start_y    <= start_y_d;
            busy       <= busy_d;
            map_valid  <= map_valid_d;
            load_error <= load_error_d;
        end
    end

    // The first cell write is issued on the payload transfer itself, so the four
    // registered writes line up exactly with the four UNPACK cycles.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chk_d        = chk_q;
        sh_d         = sh_q;
        nib_d        = nib_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_cell_d    = terrain_t'(wr_data);
        start_x_d    = start_x;
        start_y_d    = start_y;
        busy_d       = busy;
        map_valid_d  = map_valid;
        load_error_d = load_error;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d      = S_MAGIC;
                    cnt_d        = '0;
                    chk_d        = '0;
                    busy_d       = 1'b1;
                    map_valid_d  = 1'b0;
                    load_error_d = 1'b0;
                end
            end
            S_MAGIC: begin
                if (xfer_c) state_d = (byte_in == MAGIC) ? S_HDR_X : S_FAIL;
            end
            S_HDR_X: begin
                if (xfer_c) begin
                    start_x_d = byte_in;
                    state_d   = S_HDR_Y;
                end
            end
            S_HDR_Y: begin
                if (xfer_c) begin
                    start_y_d = byte_in;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer_c) begin
                    chk_d     = chk_q ^ byte_in;
                    sh_d      = byte_in[7:2];
                    nib_d     = 3'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_cell_d = terrain_t'(byte_in[1:0]);
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if ((nib_q != 3'd4) && !cells_done_c) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_cell_d = terrain_t'(sh_q[1:0]);
                    sh_d      = {2'b00, sh_q[5:2]};
                    nib_d     = nib_q + 3'd1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    state_d = cells_done_c ? S_CHECK : S_PAYLOAD;
                end
            end
            S_CHECK: begin
                if (xfer_c) begin
                    if ((byte_in == chk_q) && start_ok_c) begin
                        map_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                load_error_d = 1'b1;
                map_valid_d  = 1'b0;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_MAGIC) || (state_d == S_HDR_X) || (state_d == S_HDR_Y) ||
                       (state_d == S_PAYLOAD) || (state_d == S_CHECK);
    end

endmodule

// File: tb/tb_terrain_map_loader.sv
// Bench for terrain_map_loader: full-size 160x90 instance plus a 5x3 instance, checked
// against a frame-level model (expected write list, checksum and range rules).
module tb_terrain_map_loader;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in;
    logic        ls   [2];
    logic [7:0]  bi   [2];
    logic        bv   [2];
    logic        rdy  [2];
    logic        we   [2];
    logic [1:0]  wd   [2];
    logic [7:0]  sx   [2];
    logic [7:0]  sy   [2];
    logic        busy [2];
    logic        mv   [2];
    logic        le   [2];
    logic [15:0] wa0;
    logic [3:0]  wa1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          first_a [4];
    int          first_d [4];
    int          first_c [4];
    int          exp_q[$];
    logic [7:0]  exp_sx [2];
    logic [7:0]  exp_sy [2];
    logic [7:0]  fr[$];

    terrain_map_loader u_big (
        .clk_in(clk_in), .rst_in(rst_in), .load_start(ls[0]), .byte_in(bi[0]),
        .byte_valid(bv[0]), .byte_ready(rdy[0]), .wr_en(we[0]), .wr_addr(wa0),
        .wr_data(wd[0]), .start_x(sx[0]), .start_y(sy[0]), .busy(busy[0]),
        .map_valid(mv[0]), .load_error(le[0])
    );

    terrain_map_loader #(.MAP_W(5), .MAP_H(3), .ADDR_W(4)) u_small (
        .clk_in(clk_in), .rst_in(rst_in), .load_start(ls[1]), .byte_in(bi[1]),
        .byte_valid(bv[1]), .byte_ready(rdy[1]), .wr_en(we[1]), .wr_addr(wa1),
        .wr_data(wd[1]), .start_x(sx[1]), .start_y(sy[1]), .busy(busy[1]),
        .map_valid(mv[1]), .load_error(le[1])
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        if (d == 0)
            return {25'b0, rdy[0], we[0], wa0, wd[0], sx[0], sy[0], busy[0], mv[0], le[0]};
        return {37'b0, rdy[1], we[1], wa1, wd[1], sx[1], sy[1], busy[1], mv[1], le[1]};
    endfunction

    // Every write must match the next expected (dut, addr, cell) and never overlap byte_ready.
    task automatic monitor();
        forever begin
            @(negedge clk_in);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (we[d]) begin
                    int act;
                    act = (d << 20) | (((d == 0) ? int'(wa0) : int'(wa1)) << 2) | int'(wd[d]);
                    check("ready_low_during_write", 64'(rdy[d]), 64'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(act), 64'hFFFF_FFFF);
                    end else begin
                        check("write_addr_data", 64'(act), 64'(exp_q.pop_front()));
                    end
                    if (wr_cnt < 4) begin
                        first_a[wr_cnt] = (d == 0) ? int'(wa0) : int'(wa1);
                        first_d[wr_cnt] = int'(wd[d]);
                        first_c[wr_cnt] = cyc;
                    end
                    wr_cnt++;
                end
            end
        end
    endtask

    // Called on a negedge; returns on the negedge just after the transfer edge.
    task automatic send_byte(input int d, input logic [7:0] b, input int gap, input bit with_ls);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk_in);
        bv[d] = 1'b1;
        bi[d] = b;
        ls[d] = with_ls;
        n = 0;
        while (!rdy[d] && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!rdy[d]) begin
            check("ready_timeout", 64'(0), 64'(1));
        end else begin
            @(negedge clk_in);
        end
        bv[d] = 1'b0;
        ls[d] = 1'b0;
    endtask

    task automatic run_frame(input int d, input int w, input int h, input logic [7:0] f[$],
                             input int maxgap, input bit mid_ls, input bit ls_last);
        int cells, nb, nsend, n;
        logic [7:0] csum;
        bit ok;
        cells = w * h;
        nb    = (cells + 3) / 4;
        csum  = 8'h00;
        ok    = 1'b0;
        if (f[0] == golf_pkg::MAP_MAGIC) begin
            exp_sx[d] = f[1];
            exp_sy[d] = f[2];
            for (int i = 0; i < nb; i++) csum ^= f[3 + i];
            for (int i = 0; i < cells; i++)
                exp_q.push_back((d << 20) | (i << 2) | int'((f[3 + i / 4] >> (2 * (i % 4))) & 8'h03));
            ok    = (f[3 + nb] == csum) && (int'(f[1]) < w) && (int'(f[2]) < h);
            nsend = 4 + nb;
        end else begin
            nsend = 1;
        end
        wr_cnt = 0;
        ls[d] = 1'b1;
        @(negedge clk_in);
        ls[d] = 1'b0;
        check("busy_after_start", 64'(busy[d]), 64'(1));
        for (int i = 0; i < nsend; i++) begin
            if (mid_ls && i == 5) begin
                ls[d] = 1'b1;
                @(negedge clk_in);
                ls[d] = 1'b0;
            end
            send_byte(d, f[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)),
                      ls_last && (i == nsend - 1));
        end
        n = 0;
        while (busy[d] && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check("done_latency", 64'(n), ok ? 64'(0) : 64'(1));
        check("map_valid", 64'(mv[d]), 64'(ok));
        check("load_error", 64'(le[d]), 64'(!ok));
        check("start_x", 64'(sx[d]), 64'(exp_sx[d]));
        check("start_y", 64'(sy[d]), 64'(exp_sy[d]));
        check("pending_writes", 64'(exp_q.size()), 64'(0));
        @(negedge clk_in);
        check("idle_after_done", 64'(busy[d]), 64'(0));
    endtask

    initial begin
        rst_in = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ls[d] = 1'b0; bv[d] = 1'b0; bi[d] = 8'h00;
            exp_sx[d] = 8'h00; exp_sy[d] = 8'h00;
        end
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk_in);
        check("reset_big", outs(0), 64'(0));
        check("reset_small", outs(1), 64'(0));
        rst_in = 1'b0;
        @(negedge clk_in);

        // Full map, every cell GRASS, start (10,10)
        fr = {};
        fr.push_back(8'hA5); fr.push_back(8'd10); fr.push_back(8'd10);
        for (int i = 0; i < 3600; i++) fr.push_back(8'hAA);
        fr.push_back(8'h00);
        run_frame(0, 160, 90, fr, 0, 1'b0, 1'b0);
        check("big_write_count", 64'(wr_cnt), 64'(14400));
        check("big_map_valid_lit", 64'(mv[0]), 64'(1));
        check("big_start_x_lit", 64'(sx[0]), 64'(10));

        // 5x3: E4 unpacks to cells 0,1,2,3; top cell of last byte dropped; load_start on last byte
        fr = '{8'hA5, 8'd2, 8'd1, 8'hE4, 8'h1B, 8'hFF, 8'h4E, 8'h4E};
        run_frame(1, 5, 3, fr, 0, 1'b0, 1'b1);
        check("small_write_count", 64'(wr_cnt), 64'(15));
        for (int i = 0; i < 4; i++) begin
            check("e4_addr", 64'(first_a[i]), 64'(i));
            check("e4_data", 64'(first_d[i]), 64'(i));
            check("e4_cycle", 64'(first_c[i] - first_c[0]), 64'(i));
        end
        check("small_map_valid_lit", 64'(mv[1]), 64'(1));

        // Bad magic: no writes, error
        fr = '{8'h5A};
        run_frame(1, 5, 3, fr, 0, 1'b0, 1'b0);
        check("bad_magic_writes", 64'(wr_cnt), 64'(0));
        check("bad_magic_error_lit", 64'(le[1]), 64'(1));

        // Flipped checksum; start_x out of range; start boundaries
        fr = '{8'hA5, 8'd2, 8'd1, 8'hE4, 8'h1B, 8'hFF, 8'h4E, 8'hB1};
        run_frame(1, 5, 3, fr, 0, 1'b0, 1'b0);
        check("bad_csum_valid_lit", 64'(mv[1]), 64'(0));
        fr = '{8'hA5, 8'd200, 8'd1, 8'hE4, 8'h1B, 8'hFF, 8'h4E, 8'h4E};
        run_frame(1, 5, 3, fr, 0, 1'b0, 1'b0);
        check("bad_x_error_lit", 64'(le[1]), 64'(1));
        fr = '{8'hA5, 8'd4, 8'd2, 8'h00, 8'h55, 8'hFF, 8'h03, 8'hA9};
        run_frame(1, 5, 3, fr, 0, 1'b0, 1'b0);
        check("max_start_valid_lit", 64'(mv[1]), 64'(1));
        fr = '{8'hA5, 8'd4, 8'd3, 8'h00, 8'h55, 8'hFF, 8'h03, 8'hA9};
        run_frame(1, 5, 3, fr, 0, 1'b0, 1'b0);
        check("y_edge_error_lit", 64'(le[1]), 64'(1));

        // Random valid gaps with a mid-frame load_start
        fr = '{8'hA5, 8'd3, 8'd2, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_frame(1, 5, 3, fr, 3, 1'b1, 1'b0);
        check("gap_frame_valid_lit", 64'(mv[1]), 64'(1));

        // Reset while waiting for the second payload byte
        for (int i = 0; i < 4; i++) exp_q.push_back((1 << 20) | (i << 2) | i);
        wr_cnt = 0;
        ls[1] = 1'b1;
        @(negedge clk_in);
        ls[1] = 1'b0;
        send_byte(1, 8'hA5, 0, 1'b0);
        send_byte(1, 8'd1, 0, 1'b0);
        send_byte(1, 8'd1, 0, 1'b0);
        send_byte(1, 8'hE4, 0, 1'b0);
        repeat (6) @(negedge clk_in);
        ls[1] = 1'b1;
        @(negedge clk_in);
        ls[1] = 1'b0;
        check("busy_mid_frame", 64'(busy[1]), 64'(1));
        check("partial_writes", 64'(wr_cnt), 64'(4));
        rst_in = 1'b1;
        @(negedge clk_in);
        check("reset_mid_frame", outs(1), 64'(0));
        check("reset_big_start", 64'(sx[0]), 64'(0));
        rst_in = 1'b0;
        exp_q.delete();
        for (int d = 0; d < 2; d++) begin
            exp_sx[d] = 8'h00; exp_sy[d] = 8'h00;
        end
        @(negedge clk_in);

        fr = '{8'hA5, 8'd2, 8'd1, 8'hE4, 8'h1B, 8'hFF, 8'h4E, 8'h4E};
        run_frame(1, 5, 3, fr, 1, 1'b0, 1'b0);
        check("reload_write_count", 64'(wr_cnt), 64'(15));
        check("reload_valid_lit", 64'(mv[1]), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
